// File: rtl/viterbi_ctrl_if.sv
// Bus bundle for the Viterbi decoder frame controller.
// Handshake: a coded bit transfers on a rising clk edge where bit_vld and
// bit_rdy are both high. The source may raise bit_vld at any time. While
// bit_vld is low, bit_in is ignored. bit_rdy depends only on controller state.
// cw_vld is a one-cycle strobe with no back-pressure.
interface viterbi_ctrl_if #(
    parameter int FRAME_LEN_W = 10
);
    logic                   frm_start;
    logic [FRAME_LEN_W-1:0] frm_len;
    logic                   frm_abort;
    logic                   bit_in;
    logic                   bit_vld;
    logic                   bit_rdy;
    logic [2:0]             cw;
    logic                   cw_vld;
    logic [FRAME_LEN_W-1:0] step_cnt;
    logic                   tb_start;
    logic                   tb_done;
    logic                   busy;
    logic                   frm_done;
    logic                   frm_err;
    logic [1:0]             dbg_state;

    modport master (
        output frm_start, frm_len, frm_abort, bit_in, bit_vld, tb_done,
        input  bit_rdy, cw, cw_vld, step_cnt, tb_start, busy, frm_done, frm_err,
        input  dbg_state
    );

    modport slave (
        input  frm_start, frm_len, frm_abort, bit_in, bit_vld, tb_done,
        output bit_rdy, cw, cw_vld, step_cnt, tb_start, busy, frm_done, frm_err,
        output dbg_state
    );
endinterface

// File: rtl/viterbi_ctrl.sv
// Frame controller for a hard-decision Viterbi decoder: packs serial coded
// bits into 3-bit codewords and feeds them to the branch-distance unit. It
// waits out the pipeline in FLUSH, then starts traceback and waits for it
// to complete.
module viterbi_ctrl #(
    parameter int FRAME_LEN_W = 10,
    parameter int FLUSH_CYC   = 3
) (
    input  logic           clk,
    input  logic           rst,
    viterbi_ctrl_if.slave  bus
);
    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        TRACE   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [FRAME_LEN_W-1:0] len_q;
    logic [FRAME_LEN_W-1:0] step_cnt_q;
    logic [FRAME_LEN_W-1:0] step_cnt_d;
    logic [1:0]             bit_cnt_q;
    logic [1:0]             sh_q;        // first two bits of the codeword, g0 in [1]
    logic [FC_W-1:0]        flush_cnt_q;
    logic [2:0]             cw_q;
    logic                   cw_vld_q;
    logic                   tb_start_q;
    logic                   frm_done_q;
    logic                   frm_err_q;
    logic                   accept;

    // A bit transfers when the source offers one while collecting
    assign accept     = bus.bit_vld && (state_q == COLLECT);
    assign step_cnt_d = step_cnt_q + FRAME_LEN_W'(1);

    // Frame FSM with all pulse outputs registered; abort overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            step_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            flush_cnt_q <= '0;
            cw_q        <= '0;
            cw_vld_q    <= 1'b0;
            tb_start_q  <= 1'b0;
            frm_done_q  <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            cw_q       <= '0;
            cw_vld_q   <= 1'b0;
            tb_start_q <= 1'b0;
            frm_done_q <= 1'b0;
            frm_err_q  <= 1'b0;
            if (bus.frm_abort) begin
                // Partial codeword is dropped; step_cnt keeps its value
                state_q     <= IDLE;
                bit_cnt_q   <= '0;
                sh_q        <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (bus.frm_start && (state_q != IDLE)) begin
                    frm_err_q <= 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        if (bus.frm_start) begin
                            if (bus.frm_len != '0) begin
                                state_q    <= COLLECT;
                                len_q      <= bus.frm_len;
                                step_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                                sh_q       <= '0;
                            end else begin
                                frm_err_q <= 1'b1;
                            end
                        end
                    end
                    COLLECT: begin
                        if (accept) begin
                            if (bit_cnt_q == 2'd2) begin
                                bit_cnt_q  <= '0;
                                cw_q       <= {sh_q, bus.bit_in};
                                cw_vld_q   <= 1'b1;
                                step_cnt_q <= step_cnt_d;
                                if (step_cnt_d == len_q) begin
                                    state_q     <= FLUSH;
                                    flush_cnt_q <= FC_W'(FLUSH_CYC - 1);
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 2'd1;
                                sh_q      <= {sh_q[0], bus.bit_in};
                            end
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt_q == '0) begin
                            state_q    <= TRACE;
                            tb_start_q <= 1'b1;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - FC_W'(1);
                        end
                    end
                    TRACE: begin
                        if (bus.tb_done) begin
                            state_q    <= IDLE;
                            frm_done_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.bit_rdy   = (state_q == COLLECT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.cw        = cw_q;
    assign bus.cw_vld    = cw_vld_q;
    assign bus.step_cnt  = step_cnt_q;
    assign bus.tb_start  = tb_start_q;
    assign bus.frm_done  = frm_done_q;
    assign bus.frm_err   = frm_err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed bench for viterbi_ctrl. Inputs change and outputs are sampled
// 1 ns after each rising edge. Cycle c of a scenario is the interval that
// starts at that sample point.
module tb_viterbi_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    viterbi_ctrl_if #(.FRAME_LEN_W(10)) bus ();

    viterbi_ctrl #(.FRAME_LEN_W(10), .FLUSH_CYC(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {bit_rdy, cw_vld, cw[2:0], tb_start, frm_done, frm_err, busy}
    logic [8:0] obs;
    assign obs = {bus.bit_rdy, bus.cw_vld, bus.cw, bus.tb_start,
                  bus.frm_done, bus.frm_err, bus.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.frm_start = 1'b0;
        bus.frm_len   = '0;
        bus.frm_abort = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_vld   = 1'b0;
        bus.tb_done   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        n_cmp++;
        if (obs !== 9'b0) begin
            n_err++;
            $display("FAIL reset_obs: got %b want %b", obs, 9'b0);
        end
        n_cmp++;
        if (bus.step_cnt !== 10'd0) begin
            n_err++;
            $display("FAIL reset_step_cnt: got %0d want 0", bus.step_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    // frm_len=2, bits 1,0,1,1,1,0 back to back, tb_done two cycles after tb_start
    task automatic test_back_to_back();
        logic [5:0] bits;
        logic [8:0] exp;
        logic [9:0] exp_step;
        bits = 6'b101110;
        for (int c = 0; c < 15; c++) begin
            case (c)
                1, 2, 3, 5, 6: exp = 9'b1_0_000_0_0_0_1;
                4:             exp = 9'b1_1_101_0_0_0_1;
                7:             exp = 9'b0_1_110_0_0_0_1;
                8, 9, 11, 12:  exp = 9'b0_0_000_0_0_0_1;
                10:            exp = 9'b0_0_000_1_0_0_1;
                13:            exp = 9'b0_0_000_0_1_0_0;
                default:       exp = 9'b0;
            endcase
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL b2b_obs cyc %0d: got %b want %b", c, obs, exp);
            end
            if (c == 1 || c == 4 || c == 7 || c == 14) begin
                exp_step = (c == 1) ? 10'd0 : (c == 4) ? 10'd1 : 10'd2;
                n_cmp++;
                if (bus.step_cnt !== exp_step) begin
                    n_err++;
                    $display("FAIL b2b_step_cnt cyc %0d: got %0d want %0d", c, bus.step_cnt, exp_step);
                end
            end
            clear_inputs();
            if (c == 0) begin
                bus.frm_start = 1'b1;
                bus.frm_len   = 10'd2;
            end
            if (c >= 1 && c <= 6) begin
                bus.bit_vld = 1'b1;
                bus.bit_in  = bits[6-c];
            end
            if (c == 12) bus.tb_done = 1'b1;
            step();
        end
    endtask

    // frm_len=1, valid bits 1,1,0 in COLLECT cycles 0, 4 and 9; junk bit_in otherwise
    task automatic test_gapped();
        logic [8:0] exp;
        for (int c = 0; c < 18; c++) begin
            case (c)
                1, 2, 3, 4, 5, 6, 7, 8, 9, 10: exp = 9'b1_0_000_0_0_0_1;
                11:                            exp = 9'b0_1_110_0_0_0_1;
                12, 13, 15:                    exp = 9'b0_0_000_0_0_0_1;
                14:                            exp = 9'b0_0_000_1_0_0_1;
                16:                            exp = 9'b0_0_000_0_1_0_0;
                default:                       exp = 9'b0;
            endcase
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL gapped_obs cyc %0d: got %b want %b", c, obs, exp);
            end
            if (c == 17) begin
                n_cmp++;
                if (bus.step_cnt !== 10'd1) begin
                    n_err++;
                    $display("FAIL gapped_step_cnt: got %0d want 1", bus.step_cnt);
                end
            end
            clear_inputs();
            if (c == 0) begin
                bus.frm_start = 1'b1;
                bus.frm_len   = 10'd1;
            end
            if (c >= 1 && c <= 10) begin
                bus.bit_in  = (c == 10) ? 1'b0 : 1'b1;
                bus.bit_vld = (c == 1 || c == 5 || c == 10);
            end
            if (c == 15) bus.tb_done = 1'b1;
            step();
        end
    endtask

    // Zero-length start, then a start during FLUSH of a normal frame
    task automatic test_illegal_start();
        logic [8:0] exp;
        for (int c = 0; c < 12; c++) begin
            case (c)
                1:       exp = 9'b0_0_000_0_0_1_0;
                3, 4, 5: exp = 9'b1_0_000_0_0_0_1;
                6:       exp = 9'b0_1_001_0_0_0_1;
                7:       exp = 9'b0_0_000_0_0_0_1;
                8:       exp = 9'b0_0_000_0_0_1_1;
                9:       exp = 9'b0_0_000_1_0_0_1;
                10:      exp = 9'b0_0_000_0_1_0_0;
                default: exp = 9'b0;
            endcase
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL illegal_obs cyc %0d: got %b want %b", c, obs, exp);
            end
            if (c == 11) begin
                n_cmp++;
                if (bus.step_cnt !== 10'd1) begin
                    n_err++;
                    $display("FAIL illegal_step_cnt: got %0d want 1", bus.step_cnt);
                end
            end
            clear_inputs();
            if (c == 0) begin
                bus.frm_start = 1'b1;
                bus.frm_len   = 10'd0;
            end
            if (c == 2) begin
                bus.frm_start = 1'b1;
                bus.frm_len   = 10'd1;
            end
            if (c >= 3 && c <= 5) begin
                bus.bit_vld = 1'b1;
                bus.bit_in  = (c == 5);
            end
            if (c == 7) begin
                bus.frm_start = 1'b1;
                bus.frm_len   = 10'd5;
            end
            if (c == 9) bus.tb_done = 1'b1;
            step();
        end
    endtask

    // Abort with the third bit of codeword 1, abort+start in IDLE, then frame 0,1,1
    task automatic test_abort();
        logic [8:0] exp;
        for (int c = 0; c < 15; c++) begin
            case (c)
                1, 2, 3, 6, 7, 8: exp = 9'b1_0_000_0_0_0_1;
                9:                exp = 9'b0_1_011_0_0_0_1;
                10, 11:           exp = 9'b0_0_000_0_0_0_1;
                12:               exp = 9'b0_0_000_1_0_0_1;
                13:               exp = 9'b0_0_000_0_1_0_0;
                default:          exp = 9'b0;
            endcase
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL abort_obs cyc %0d: got %b want %b", c, obs, exp);
            end
            if (c == 4 || c == 9) begin
                n_cmp++;
                if (bus.step_cnt !== ((c == 4) ? 10'd0 : 10'd1)) begin
                    n_err++;
                    $display("FAIL abort_step_cnt cyc %0d: got %0d want %0d", c, bus.step_cnt, (c == 4) ? 0 : 1);
                end
            end
            clear_inputs();
            case (c)
                0: begin bus.frm_start = 1'b1; bus.frm_len = 10'd1; end
                1: begin bus.bit_vld = 1'b1; bus.bit_in = 1'b1; end
                2: begin bus.bit_vld = 1'b1; bus.bit_in = 1'b0; end
                3: begin bus.frm_abort = 1'b1; bus.bit_vld = 1'b1; bus.bit_in = 1'b1; end
                4: begin bus.frm_abort = 1'b1; bus.frm_start = 1'b1; bus.frm_len = 10'd1; end
                5: begin bus.frm_start = 1'b1; bus.frm_len = 10'd1; end
                6: begin bus.bit_vld = 1'b1; bus.bit_in = 1'b0; end
                7, 8: begin bus.bit_vld = 1'b1; bus.bit_in = 1'b1; end
                12: bus.tb_done = 1'b1;
                default: ;
            endcase
            step();
        end
    endtask

    // tb_done held high from before the frame through the tb_start cycle
    task automatic test_tb_done_held();
        logic [8:0] exp;
        for (int c = 0; c < 10; c++) begin
            case (c)
                1, 2, 3: exp = 9'b1_0_000_0_0_0_1;
                4:       exp = 9'b0_1_111_0_0_0_1;
                5, 6:    exp = 9'b0_0_000_0_0_0_1;
                7:       exp = 9'b0_0_000_1_0_0_1;
                8:       exp = 9'b0_0_000_0_1_0_0;
                default: exp = 9'b0;
            endcase
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL tbheld_obs cyc %0d: got %b want %b", c, obs, exp);
            end
            clear_inputs();
            bus.tb_done = (c < 9);
            if (c == 0) begin
                bus.frm_start = 1'b1;
                bus.frm_len   = 10'd1;
            end
            if (c >= 1 && c <= 3) begin
                bus.bit_vld = 1'b1;
                bus.bit_in  = 1'b1;
            end
            step();
        end
    endtask

    // rst pulsed in TRACE, then a fresh frame with bits 0,1,0
    task automatic test_reset_mid_frame();
        logic [8:0] exp;
        for (int c = 0; c < 9; c++) begin
            case (c)
                1, 2, 3:  exp = 9'b1_0_000_0_0_0_1;
                4:        exp = 9'b0_1_100_0_0_0_1;
                5, 6, 8:  exp = 9'b0_0_000_0_0_0_1;
                7:        exp = 9'b0_0_000_1_0_0_1;
                default:  exp = 9'b0;
            endcase
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL rstmid_obs cyc %0d: got %b want %b", c, obs, exp);
            end
            if (c == 8) break;
            clear_inputs();
            if (c == 0) begin
                bus.frm_start = 1'b1;
                bus.frm_len   = 10'd1;
            end
            if (c >= 1 && c <= 3) begin
                bus.bit_vld = 1'b1;
                bus.bit_in  = (c == 1);
            end
            step();
        end
        rst = 1'b1;
        #2;
        n_cmp++;
        if (obs !== 9'b0) begin
            n_err++;
            $display("FAIL rstmid_async_obs: got %b want %b", obs, 9'b0);
        end
        n_cmp++;
        if (bus.step_cnt !== 10'd0) begin
            n_err++;
            $display("FAIL rstmid_async_step_cnt: got %0d want 0", bus.step_cnt);
        end
        step();
        rst = 1'b0;
        bus.tb_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (obs !== 9'b0) begin
                n_err++;
                $display("FAIL rstmid_after_obs cyc %0d: got %b want %b", c, obs, 9'b0);
            end
        end
        for (int c = 0; c < 10; c++) begin
            case (c)
                1, 2, 3: exp = 9'b1_0_000_0_0_0_1;
                4:       exp = 9'b0_1_010_0_0_0_1;
                5, 6:    exp = 9'b0_0_000_0_0_0_1;
                7:       exp = 9'b0_0_000_1_0_0_1;
                8:       exp = 9'b0_0_000_0_1_0_0;
                default: exp = 9'b0;
            endcase
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL rstmid_next_obs cyc %0d: got %b want %b", c, obs, exp);
            end
            if (c == 4) begin
                n_cmp++;
                if (bus.step_cnt !== 10'd1) begin
                    n_err++;
                    $display("FAIL rstmid_next_step_cnt: got %0d want 1", bus.step_cnt);
                end
            end
            clear_inputs();
            if (c == 0) begin
                bus.frm_start = 1'b1;
                bus.frm_len   = 10'd1;
            end
            if (c >= 1 && c <= 3) begin
                bus.bit_vld = 1'b1;
                bus.bit_in  = (c == 2);
            end
            if (c == 7) bus.tb_done = 1'b1;
            step();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_gapped();
        test_illegal_start();
        test_abort();
        test_tb_done_held();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
